// File: rtl/frame_pkg.sv
// Shared frame field layout, unit-id width and dispatcher state encoding.
// Included by frame_dispatch and its bench; no logic of its own.
package frame_pkg;

  localparam int UNIT_LSB = 22;
  localparam int UNIT_W   = 3;

  typedef struct packed {
    logic              parity;
    logic [5:0]        reserved;
    logic [UNIT_W-1:0] unit_id;
    logic [4:0]        reg_addr;
    logic              wr_rd_s;
    logic [7:0]        wr_data;
    logic [7:0]        op_id;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous first-word-fall-through ingress buffer; head word visible the edge after a push.
// Pushes while full and pops while empty are ignored; a push and pop on one edge keep occupancy.
module frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dat   = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frame_dispatch.sv
// Buffers host frames and issues each as a one-hot load strobe plus registered frame; FRAME_PARITY_CHECK_EN adds parity drop.
// load_out rises the edge after acceptance into an empty FIFO, one dispatch per 3 cycles; frame_ready = FIFO not full.
module frame_dispatch
  import frame_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_valid,
  input  logic [FRAME_WIDTH-1:0] frame_data,
  output logic                   frame_ready,
  output logic [NUM_SW_INST-1:0] load_out,
  output logic [FRAME_WIDTH-1:0] frame_out,
  output logic [7:0]             drop_cnt,
  output logic                   fifo_empty
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_unit_ok;
  logic                   w_par_ok;
  logic [UNIT_W-1:0]      w_unit;
  logic [NUM_SW_INST-1:0] w_unit_onehot;
  logic [FRAME_WIDTH-1:0] w_head_dat;
  logic [FRAME_WIDTH-1:0] r_frame_out;
  logic [FRAME_WIDTH-1:0] w_frame_nxt;
  logic [NUM_SW_INST-1:0] r_load_out;
  logic [NUM_SW_INST-1:0] w_load_nxt;
  logic [7:0]             r_drop_cnt;
  logic [7:0]             w_drop_nxt;

  assign frame_ready = ~w_full;
  assign fifo_empty  = w_empty;
  assign load_out    = r_load_out;
  assign frame_out   = r_frame_out;
  assign drop_cnt    = r_drop_cnt;
  assign w_push      = frame_valid & ~w_full;

  frame_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (frame_data),
    .i_pop   (w_pop),
    .o_dat   (w_head_dat),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_unit    = w_head_dat[UNIT_LSB +: UNIT_W];
  assign w_unit_ok = ({1'b0, w_unit} < (UNIT_W+1)'(NUM_SW_INST));

`ifdef FRAME_PARITY_CHECK_EN
  assign w_par_ok = ~(^w_head_dat);
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_unit_onehot = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      w_unit_onehot[i] = (w_unit == UNIT_W'(i));
    end
  end

  // Head is consumed in IDLE whether it dispatches or drops, so bad frames never stall the queue.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_nxt  = r_load_out;
    w_frame_nxt = r_frame_out;
    w_drop_nxt  = r_drop_cnt;
    unique case (r_state)
      IDLE: begin
        w_load_nxt = '0;
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_unit_ok && w_par_ok) begin
            w_frame_nxt = w_head_dat;
            w_load_nxt  = w_unit_onehot;
            w_state_nxt = ISSUE;
          end else if (r_drop_cnt != 8'hFF) begin
            w_drop_nxt = r_drop_cnt + 8'd1;
          end
        end
      end
      ISSUE: begin
        w_load_nxt  = '0;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        w_load_nxt  = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_load_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_load_out  <= '0;
      r_frame_out <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_out  <= w_load_nxt;
      r_frame_out <= w_frame_nxt;
      r_drop_cnt  <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_frame_dispatch.sv
// Randomised and directed bench for frame_dispatch against a queue-based reference model.
module tb_frame_dispatch;

  localparam int NSW   = 5;
  localparam int FW    = 32;
  localparam int DEPTH = 4;

  logic           clk         = 1'b0;
  logic           rst_n       = 1'b0;
  logic           frame_valid = 1'b0;
  logic [FW-1:0]  frame_data  = '0;
  logic           frame_ready;
  logic [NSW-1:0] load_out;
  logic [FW-1:0]  frame_out;
  logic [7:0]     drop_cnt;
  logic           fifo_empty;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  frame_dispatch #(
    .NUM_SW_INST (NSW),
    .FRAME_WIDTH (FW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .load_out    (load_out),
    .frame_out   (frame_out),
    .drop_cnt    (drop_cnt),
    .fifo_empty  (fifo_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted frames in a queue; a dispatch blocks further pops for two cycles.
  logic [FW-1:0]  m_q[$];
  int             m_busy  = 0;
  logic [NSW-1:0] m_load  = '0;
  logic [FW-1:0]  m_frame = '0;
  int             m_drop  = 0;

  function automatic bit m_ok(input logic [FW-1:0] f);
    bit ok;
    ok = (int'(f[24:22]) < NSW);
`ifdef FRAME_PARITY_CHECK_EN
    if (^f) ok = 1'b0;
`endif
    return ok;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit            acc;
    logic [FW-1:0] f;
    if (!rst_n) begin
      m_q.delete();
      m_busy  = 0;
      m_load  = '0;
      m_frame = '0;
      m_drop  = 0;
    end else begin
      acc    = frame_valid && (m_q.size() < DEPTH);
      m_load = '0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (m_q.size() > 0) begin
        f = m_q.pop_front();
        if (m_ok(f)) begin
          m_frame = f;
          m_load  = NSW'(1) << f[24:22];
          m_busy  = 2;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (acc) m_q.push_back(frame_data);
    end
  end

  int            pulse_cyc[$];
  logic [FW-1:0] pulse_frame[$];

  always @(negedge clk) begin
    chk("frame_ready", 32'(frame_ready), 32'(m_q.size() < DEPTH));
    chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
    chk("load_out", 32'(load_out), 32'(m_load));
    chk("frame_out", frame_out, m_frame);
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("load_onehot", 32'($countones(load_out) <= 1), 32'd1);
    if (load_out != '0) begin
      pulse_cyc.push_back(cyc);
      pulse_frame.push_back(frame_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f);
    bit rdy;
    int k;
    k           = 0;
    rdy         = 1'b0;
    frame_valid = 1'b1;
    frame_data  = f;
    while (!rdy && k < 64) begin
      rdy = frame_ready;
      tick(1);
      k++;
    end
    if (!rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted time=%0t", $time);
    end
    frame_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_busy != 0) && k < 200) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", 32'(k < 200), 32'd1);
  endtask

  function automatic logic [FW-1:0] even_par(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r     = f;
    r[31] = ^f[30:0];
    return r;
  endfunction

  initial begin
    logic [FW-1:0] burst [6];
    logic [FW-1:0] f;
    int            p0;
    bit            saw_full;

    // Reset state
    rst_n = 1'b0;
    tick(2);
    chk("rst_load", 32'(load_out), 32'd0);
    chk("rst_frame", frame_out, 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready", 32'(frame_ready), 32'd1);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Single frame to unit 1
    p0 = pulse_cyc.size();
    send(32'h004B_A53C);
    tick(1);
    chk("single_load", 32'(load_out), 32'h0000_0002);
    chk("single_frame", frame_out, 32'h004B_A53C);
    tick(1);
    chk("single_load_clr", 32'(load_out), 32'd0);
    chk("single_frame_hold1", frame_out, 32'h004B_A53C);
    tick(1);
    chk("single_frame_hold2", frame_out, 32'h004B_A53C);
    chk("single_pulses", 32'(pulse_cyc.size() - p0), 32'd1);

    // Unit id 6 is out of range
    p0 = pulse_cyc.size();
    send(32'h0180_0000);
    tick(2);
    chk("bad_unit_drop", 32'(drop_cnt), 32'd1);
    chk("bad_unit_pulses", 32'(pulse_cyc.size() - p0), 32'd0);

    // Odd-parity frame to unit 1
    send(32'h004B_A53D);
    tick(1);
`ifdef FRAME_PARITY_CHECK_EN
    chk("parity_drop", 32'(drop_cnt), 32'd2);
    chk("parity_load", 32'(load_out), 32'd0);
`else
    chk("parity_load", 32'(load_out), 32'h0000_0002);
    chk("parity_frame", frame_out, 32'h004B_A53D);
`endif
    wait_idle();

    // Back-to-back burst of six
    for (int i = 0; i < 6; i++) begin
      f = '0;
      f[24:22] = 3'(i % NSW);
      f[21:17] = 5'(i + 3);
      f[16]    = 1'b1;
      f[15:8]  = 8'(i * 17 + 1);
      f[7:0]   = 8'(8'h40 + i);
      burst[i] = even_par(f);
    end
    p0       = pulse_cyc.size();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(burst[i]);
      if (!frame_ready) saw_full = 1'b1;
    end
    chk("burst_saw_full", 32'(saw_full), 32'd1);
    wait_idle();
    tick(2);
    chk("burst_pulses", 32'(pulse_cyc.size() - p0), 32'd6);
    if (pulse_cyc.size() - p0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("burst_order", pulse_frame[p0 + i], burst[i]);
        if (i > 0) chk("burst_gap", 32'(pulse_cyc[p0 + i] - pulse_cyc[p0 + i - 1]), 32'd3);
      end
    end

    // Reset while in HOLD with two frames queued
    send(burst[0]);
    send(burst[1]);
    send(burst[2]);
    chk("hold_queue_model", 32'(m_q.size()), 32'd2);
    p0    = pulse_cyc.size();
    rst_n = 1'b0;
    #1;
    chk("midrst_load", 32'(load_out), 32'd0);
    chk("midrst_frame", frame_out, 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    tick(2);
    rst_n = 1'b1;
    chk("midrst_ready", 32'(frame_ready), 32'd1);
    tick(30);
    chk("midrst_no_pulse", 32'(pulse_cyc.size() - p0), 32'd0);

    // Saturation with 300 invalid frames
    for (int i = 0; i < 300; i++) begin
      f = $urandom;
      f[24:22] = 3'd7;
      send(f);
    end
    wait_idle();
    tick(2);
    chk("drop_saturate", 32'(drop_cnt), 32'd255);

    // Random traffic with a reset in the middle
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 800; i++) begin
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[24:22] = 3'($urandom_range(0, NSW - 1));
      frame_valid = ($urandom_range(0, 3) != 0);
      frame_data  = f;
      if (i == 400) rst_n = 1'b0;
      if (i == 402) rst_n = 1'b1;
      tick(1);
    end
    frame_valid = 1'b0;
    wait_idle();
    tick(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
